// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
//   arb_state_t : arbiter FSM states (idle / waiting on a read)
//   req_id_t    : requester identity (CPU datapath or DMA/loader)
//   CNT_W       : width of the read-latency down-counter
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic {ST_IDLE, ST_RD_WAIT} arb_state_t;
    typedef enum logic {REQ_CPU, REQ_DMA} req_id_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way request picker.
// Build option: define ARB_ROUND_ROBIN_EN to alternate on ties using
// last_gnt; without it the CPU always wins a tie and last_gnt is ignored.
// Ports:
//   cpu_req, dma_req : in  request levels
//   last_gnt         : in  requester granted most recently
//   winner           : out selected requester (meaningful only when any=1)
//   any              : out at least one request present
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dma_req,
    input  req_id_t last_gnt,
    output req_id_t winner,
    output logic    any
);

    assign any = cpu_req | dma_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = REQ_CPU;
        if (cpu_req && dma_req) begin
            // Tie: hand the port to whoever did not get it last time.
            winner = (last_gnt == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (dma_req) begin
            winner = REQ_DMA;
        end
    end
`else
    // Fixed priority has no use for the grant history.
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt;

    always_comb begin
        winner = REQ_CPU;
        if (!cpu_req && dma_req) begin
            winner = REQ_DMA;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one instruction/data memory port between the multicycle CPU
// datapath and a DMA/loader. Writes finish in the grant cycle; reads hold
// the port for RD_LAT cycles and return data on the owner's rvalid pulse.
// Build option: ARB_ROUND_ROBIN_EN (see mem_arb_pick) selects round-robin
// tie breaking instead of fixed CPU priority.
// Parameters: AW address width, DW data width, RD_LAT read latency (1..15).
// Ports:
//   clk, reset                  : clock, async active-low reset
//   cpu_req/we/addr/wdata       : CPU request (level, held until cpu_gnt)
//   cpu_gnt/rvalid/rdata        : CPU grant, read-data pulse and data
//   dma_*                       : same set for the DMA/loader requester
//   mem_en/we/addr/wdata        : memory macro access signals
//   mem_rdata                   : memory read data, RD_LAT cycles after mem_en
//   dbg_state                   : current arbiter FSM state
//
// Handshake: a requester holds req (with we/addr/wdata stable) until it
// sees gnt in a cycle; that cycle is the access. For a read, rvalid pulses
// for exactly one cycle RD_LAT cycles after gnt with rdata valid alongside.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 64,
    parameter int RD_LAT = 2
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output arb_state_t    dbg_state
);

    // The grant cycle itself counts as one latency cycle, so the wait
    // counter starts one short of RD_LAT.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    req_id_t          owner, owner_nxt;
    req_id_t          last_gnt, last_gnt_nxt;
    req_id_t          winner;
    logic             any;

    mem_arb_pick u_pick (
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .last_gnt (last_gnt),
        .winner   (winner),
        .any      (any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            owner    <= REQ_CPU;
            last_gnt <= REQ_DMA;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        owner_nxt    = owner;
        last_gnt_nxt = last_gnt;
        cpu_gnt      = 1'b0;
        dma_gnt      = 1'b0;
        cpu_rvalid   = 1'b0;
        dma_rvalid   = 1'b0;
        cpu_rdata    = '0;
        dma_rdata    = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        // Outputs are forced low while reset is held, not just after the
        // state register clears, so pending requests cannot leak a grant.
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        mem_en       = 1'b1;
                        last_gnt_nxt = winner;
                        if (winner == REQ_CPU) begin
                            cpu_gnt   = 1'b1;
                            mem_we    = cpu_we;
                            mem_addr  = cpu_addr;
                            mem_wdata = cpu_wdata;
                        end else begin
                            dma_gnt   = 1'b1;
                            mem_we    = dma_we;
                            mem_addr  = dma_addr;
                            mem_wdata = dma_wdata;
                        end
                        // Writes retire now; only reads occupy the port.
                        if (!mem_we) begin
                            state_nxt = ST_RD_WAIT;
                            cnt_nxt   = CNT_LOAD;
                            owner_nxt = winner;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        state_nxt = ST_IDLE;
                        if (owner == REQ_CPU) begin
                            cpu_rvalid = 1'b1;
                            cpu_rdata  = mem_rdata;
                        end else begin
                            dma_rvalid = 1'b1;
                            dma_rdata  = mem_rdata;
                        end
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
